vga_fb_reader: RTL
==================

VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 Parameters (name, default, meaning) SHALL be one per line:
- H_ACT 640: visible columns.
- H_FP 16, H_SYNC 96, H_BP 48: horizontal porch and sync lengths, in pixel ticks.
- V_ACT 480: visible lines.
- V_FP 10, V_SYNC 2, V_BP 33: vertical porch and sync lengths, in lines.
- IMG_W 256, IMG_H 256: framebuffer image size, placed at the top-left of the screen.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 pix_ce  input  1  pixel-tick enable; counters and pipeline advance only when high.
REQ-005 start  input  1  begins scanout when in IDLE.
REQ-006 fb_rd_en  output  1  framebuffer read strobe.
REQ-007 fb_addr  output  16  framebuffer word address, equal to y*IMG_W+x.
REQ-008 fb_rdata  input  18  read data; valid on the first pix_ce tick after the request tick; bits [1:0] are the colour code.
REQ-009 cursor_en  input  1  enables the cursor overlay.
REQ-010 cursor_x  input  10  cursor column.
REQ-011 cursor_y  input  10  cursor line.
REQ-012 pixel  output  24  RGB888 output.
REQ-013 hsync  output  1  horizontal sync, active-low.
REQ-014 vsync  output  1  vertical sync, active-low.
REQ-015 blank_n  output  1  high during the visible area.
REQ-016 frame_start  output  1  one-clk pulse marking the start of a frame.

Function
REQ-017 FSM states SHALL be IDLE and RUN.
- IDLE -> RUN when start=1 is sampled on a pix_ce tick.
- RUN has no exit except reset.
- start is ignored while in RUN.
REQ-018 In IDLE the outputs SHALL be:
- counters held at 0
- fb_rd_en=0
- hsync=1, vsync=1, blank_n=0, pixel=0
REQ-019 Horizontal counter hc SHALL run 0..H_ACT+H_FP+H_SYNC+H_BP-1 (799 at defaults) and then wrap to 0.
REQ-020 Vertical counter vc SHALL increment only when hc wraps, run 0..524 at defaults, and then wrap to 0.
REQ-021 Raw hsync SHALL be low for hc in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC-1], i.e. 656..751 at defaults.
REQ-022 Raw vsync SHALL be low for vc in [490, 491] at defaults.
REQ-023 fb_rd_en SHALL be high on the tick where hc<IMG_W and vc<IMG_H, with fb_addr={vc[7:0],hc[7:0]}.
REQ-024 Pipeline timing:
- Stage 1: counter tick and address.
- Stage 2: data return.
- Stage 3: palette register.
- Total latency: 2 pix_ce ticks from counter to pixel output.
- hsync, vsync, blank_n and the in_image/cursor flags SHALL be delayed 2 ticks so they stay aligned with pixel.
REQ-025 Palette for fb_rdata[1:0]: 00 -> 24'h000000, 01 -> 24'hFF0000, 10 -> 24'h00FF00, 11 -> 24'h0000FF.
REQ-026 Visible pixels outside the image SHALL be 24'h202020.
REQ-027 Blanked pixels SHALL be 24'h000000.
REQ-028 fb_rdata bits [17:2] SHALL be ignored.
REQ-029 Cursor overlay:
- When cursor_en=1 and the pixel position equals (cursor_x,cursor_y), pixel SHALL be 24'hFFFFFF.
- The overlay overrides the palette and the border colour, but not blanking.
REQ-030 cursor_x, cursor_y and cursor_en SHALL be captured once per frame, at vc=0, hc=0, so the cursor never tears mid-frame.
REQ-031 A cursor position outside the visible area SHALL produce no overlay.
REQ-032 frame_start SHALL pulse for exactly one clk on the tick where hc=0 and vc=0 in RUN, including the first tick after leaving IDLE.
REQ-033 When pix_ce=0, every register SHALL hold its value and frame_start SHALL be 0.
REQ-034 Wrap boundary: at hc=799 and vc=524 both counters SHALL wrap to 0 on the same tick.

Reset
REQ-035 While rst=0 the block SHALL, asynchronously:
- enter IDLE
- clear the counters, pipeline registers and cursor latches
- drive pixel=0, hsync=1, vsync=1, blank_n=0, fb_rd_en=0, fb_addr=0, frame_start=0
REQ-036 Reset asserted mid-frame SHALL abort the frame.
REQ-037 After rst returns to 1, scanout SHALL resume only after a new start.

Verification
REQ-038 Reset then start=1 with pix_ce=1 permanently -> frame_start pulses on the first tick; hsync period is 800 ticks with a 96-tick low phase; vsync period is 420000 ticks with a 1600-tick low phase.
REQ-039 Framebuffer model with 1-tick latency, word at address 0x0103 = 18'h00002 -> pixel at screen (x=3, y=1) is 24'h00FF00, appearing 2 ticks after hc=3, vc=1.
REQ-040 Screen position x=300, y=10 -> pixel 24'h202020, fb_rd_en=0.
REQ-041 cursor_en=1, cursor at (5,5), changed to (6,6) mid-frame -> white pixel at (5,5) in the current frame and at (6,6) only in the next frame.
REQ-042 pix_ce toggling 1/0 every clk -> all timings stretch by exactly 2x; outputs are identical per tick.
REQ-043 rst=0 at vc=100 -> outputs reach reset values immediately; with start held low afterwards, outputs stay in the IDLE state.

Source files
------------

// File: rtl/vga_fb_reader.sv
// VGA scanout engine: raster counters, framebuffer read requests and a two-tick
// pixel pipeline with a 2-bit palette, border colour and a per-frame latched cursor.
module vga_fb_reader #(
  parameter int unsigned H_ACT  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_ACT  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pix_ce_i,
  input  logic        start_i,
  output logic        fb_rd_en_o,
  output logic [15:0] fb_addr_o,
  input  logic [17:0] fb_rdata_i,
  input  logic        cursor_en_i,
  input  logic [9:0]  cursor_x_i,
  input  logic [9:0]  cursor_y_i,
  output logic [23:0] pixel_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        blank_n_o,
  output logic        frame_start_o
);

  localparam int unsigned HTot = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW   = $clog2(HTot);
  localparam int unsigned VW   = $clog2(VTot);

  localparam logic [23:0] ColBorder = 24'h202020;
  localparam logic [23:0] ColCursor = 24'hFFFFFF;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hc_q, hc_d;
  logic [VW-1:0]   vc_q, vc_d;
  logic            cur_en_q, cur_en_d;
  logic [9:0]      cur_x_q, cur_x_d;
  logic [9:0]      cur_y_q, cur_y_d;

  // Stage-1 flags, aligned with the cycle in which fb_rdata_i returns
  logic            s1_vis_q, s1_vis_d;
  logic            s1_img_q, s1_img_d;
  logic            s1_cur_q, s1_cur_d;
  logic            s1_hs_q, s1_hs_d;
  logic            s1_vs_q, s1_vs_d;

  // Stage-2 (output) registers
  logic [23:0]     pix_q, pix_d;
  logic            s2_hs_q, s2_hs_d;
  logic            s2_vs_q, s2_vs_d;
  logic            s2_bn_q, s2_bn_d;

  logic            run;
  logic            origin;
  logic [31:0]     hc_w, vc_w;
  logic            in_img, vis, hs_raw, vs_raw, cur_hit;
  logic            cen_eff;
  logic [9:0]      cx_eff, cy_eff;
  logic            unused_rdata;

  assign unused_rdata = ^fb_rdata_i[17:2];

  function automatic logic [23:0] palette(input logic [1:0] code);
    logic [23:0] col;
    case (code)
      2'b00:   col = 24'h000000;
      2'b01:   col = 24'hFF0000;
      2'b10:   col = 24'h00FF00;
      default: col = 24'h0000FF;
    endcase
    return col;
  endfunction

  always_comb begin
    run    = (state_q == StRun);
    hc_w   = 32'(hc_q);
    vc_w   = 32'(vc_q);
    origin = run && (hc_q == '0) && (vc_q == '0);

    state_d = state_q;
    if ((state_q == StIdle) && pix_ce_i && start_i) begin
      state_d = StRun;
    end

    hc_d = hc_q;
    vc_d = vc_q;
    if (run) begin
      if (hc_w == HTot - 1) begin
        hc_d = '0;
        vc_d = (vc_w == VTot - 1) ? '0 : vc_q + VW'(1);
      end else begin
        hc_d = hc_q + HW'(1);
      end
    end

    in_img = run && (hc_w < IMG_W) && (vc_w < IMG_H);
    vis    = run && (hc_w < H_ACT) && (vc_w < V_ACT);
    hs_raw = !(run && (hc_w >= H_ACT + H_FP) && (hc_w < H_ACT + H_FP + H_SYNC));
    vs_raw = !(run && (vc_w >= V_ACT + V_FP) && (vc_w < V_ACT + V_FP + V_SYNC));

    // The frame's first pixel already sees the freshly sampled cursor inputs
    cen_eff = origin ? cursor_en_i : cur_en_q;
    cx_eff  = origin ? cursor_x_i  : cur_x_q;
    cy_eff  = origin ? cursor_y_i  : cur_y_q;
    cur_hit = cen_eff && vis && (hc_w == 32'(cx_eff)) && (vc_w == 32'(cy_eff));

    cur_en_d = cur_en_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    if (origin) begin
      cur_en_d = cursor_en_i;
      cur_x_d  = cursor_x_i;
      cur_y_d  = cursor_y_i;
    end

    s1_vis_d = vis;
    s1_img_d = in_img;
    s1_cur_d = cur_hit;
    s1_hs_d  = hs_raw;
    s1_vs_d  = vs_raw;

    if (!s1_vis_q) begin
      pix_d = 24'h000000;
    end else if (s1_cur_q) begin
      pix_d = ColCursor;
    end else if (s1_img_q) begin
      pix_d = palette(fb_rdata_i[1:0]);
    end else begin
      pix_d = ColBorder;
    end
    s2_hs_d = s1_hs_q;
    s2_vs_d = s1_vs_q;
    s2_bn_d = s1_vis_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      hc_q     <= '0;
      vc_q     <= '0;
      cur_en_q <= 1'b0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      s1_vis_q <= 1'b0;
      s1_img_q <= 1'b0;
      s1_cur_q <= 1'b0;
      s1_hs_q  <= 1'b1;
      s1_vs_q  <= 1'b1;
      pix_q    <= '0;
      s2_hs_q  <= 1'b1;
      s2_vs_q  <= 1'b1;
      s2_bn_q  <= 1'b0;
    end else if (pix_ce_i) begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      cur_en_q <= cur_en_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      s1_vis_q <= s1_vis_d;
      s1_img_q <= s1_img_d;
      s1_cur_q <= s1_cur_d;
      s1_hs_q  <= s1_hs_d;
      s1_vs_q  <= s1_vs_d;
      pix_q    <= pix_d;
      s2_hs_q  <= s2_hs_d;
      s2_vs_q  <= s2_vs_d;
      s2_bn_q  <= s2_bn_d;
    end
  end

  assign fb_rd_en_o    = in_img;
  assign fb_addr_o     = 16'(vc_w * IMG_W + hc_w);
  assign frame_start_o = origin && pix_ce_i;
  assign pixel_o       = pix_q;
  assign hsync_o       = s2_hs_q;
  assign vsync_o       = s2_vs_q;
  assign blank_n_o     = s2_bn_q;

endmodule
